// File: rtl/latch_bank_arbiter.sv
// Round-robin write arbiter driving a shared bank of level-sensitive latch words.
// Build option LATCH_VERIFY_EN adds a HOLD-cycle readback compare that drives the sticky err flag.
module latch_bank_arbiter #(
  parameter int NREQ        = 4,
  parameter int DW          = 8,
  parameter int AW          = 2,
  parameter int OPEN_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      wdata,
  input  logic [NREQ*AW-1:0]      waddr,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [DW-1:0]           lat_d,
  output logic [(1<<AW)-1:0]      lat_en,
  input  logic [(1<<AW)*DW-1:0]   lat_q,
  output logic                    busy,
  output logic                    err
);
  localparam int NW = 1 << AW;
  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

  logic [DW-1:0] wd [NREQ];
  logic [AW-1:0] wa [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign wd[gi] = wdata[gi*DW +: DW];
      assign wa[gi] = waddr[gi*AW +: AW];
    end
  endgenerate

  state_t        state, state_n;
  logic [RW-1:0] rr, rr_n, sel, sel_n, pick, idx;
  logic          found;
  logic [DW-1:0] cap_d, cap_d_n, d_n;
  logic [AW-1:0] cap_a, cap_a_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NREQ-1:0] gnt_n, done_n;
  logic [NW-1:0] en_n;

  // first asserted requester strictly after the last winner, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = RW'((int'(rr) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    rr_n    = rr;
    sel_n   = sel;
    cap_d_n = cap_d;
    cap_a_n = cap_a;
    cnt_n   = cnt;
    gnt_n   = gnt;
    done_n  = '0;
    en_n    = '0;
    d_n     = lat_d;
    case (state)
      IDLE: begin
        gnt_n = '0;
        if (found) begin
          state_n = SETUP;
          sel_n   = pick;
          rr_n    = pick;
          cap_d_n = wd[pick];
          cap_a_n = wa[pick];
          gnt_n   = NREQ'(1) << pick;
          d_n     = wd[pick];
        end
      end
      SETUP: begin
        state_n = OPEN;
        en_n    = NW'(1) << cap_a;
        cnt_n   = CW'(OPEN_CYCLES - 1);
      end
      OPEN: begin
        if (cnt == '0) begin
          state_n = HOLD;
          done_n  = NREQ'(1) << sel;
        end else begin
          cnt_n = cnt - CW'(1);
          en_n  = NW'(1) << cap_a;
        end
      end
      HOLD: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr     <= RW'(NREQ - 1);
      sel    <= '0;
      cap_d  <= '0;
      cap_a  <= '0;
      cnt    <= '0;
      gnt    <= '0;
      done   <= '0;
      lat_en <= '0;
      lat_d  <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      rr     <= rr_n;
      sel    <= sel_n;
      cap_d  <= cap_d_n;
      cap_a  <= cap_a_n;
      cnt    <= cnt_n;
      gnt    <= gnt_n;
      done   <= done_n;
      lat_en <= en_n;
      lat_d  <= d_n;
      busy   <= (state_n != IDLE);
    end
  end

`ifdef LATCH_VERIFY_EN
  logic [DW-1:0] q_w [NW];
  generate
    for (gi = 0; gi < NW; gi++) begin : g_q
      assign q_w[gi] = lat_q[gi*DW +: DW];
    end
  endgenerate

  // word has been closed for a cycle by HOLD, so Q is settled
  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (state == HOLD && q_w[cap_a] != cap_d)
      err <= 1'b1;
  end
`else
  logic unused_lat_q;
  assign unused_lat_q = ^lat_q;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed bench for latch_bank_arbiter: vector table plus corner-case sequences.
module tb_latch_bank_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef LATCH_VERIFY_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic [3:0]  req = '0;
  logic [31:0] wdata = '0;
  logic [7:0]  waddr = '0;
  logic [3:0]  gnt, done, lat_en;
  logic [7:0]  lat_d;
  logic [31:0] lat_q;
  logic        busy, err;

  logic [7:0] bank [4];
  logic       corrupt = 1'b0;
  initial for (int w = 0; w < 4; w++) bank[w] = '0;
  always @(posedge clk)
    for (int w = 0; w < 4; w++) if (lat_en[w]) bank[w] <= lat_d;
  assign lat_q = {bank[3], corrupt ? 8'h00 : bank[2], bank[1], bank[0]};

  latch_bank_arbiter #(.NREQ(4), .DW(8), .AW(2), .OPEN_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .waddr(waddr),
    .gnt(gnt), .done(done), .lat_d(lat_d), .lat_en(lat_en), .lat_q(lat_q),
    .busy(busy), .err(err));

  logic [3:0]  req1 = '0, req5 = '0;
  logic [31:0] wdata_b = '0;
  logic [7:0]  waddr_b = '0;
  logic [3:0]  gnt1, done1, en1, gnt5, done5, en5;
  logic [7:0]  d1, d5;
  logic        busy1, err1, busy5, err5;

  latch_bank_arbiter #(.NREQ(4), .DW(8), .AW(2), .OPEN_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .req(req1), .wdata(wdata_b), .waddr(waddr_b),
    .gnt(gnt1), .done(done1), .lat_d(d1), .lat_en(en1), .lat_q(32'h0),
    .busy(busy1), .err(err1));

  latch_bank_arbiter #(.NREQ(4), .DW(8), .AW(2), .OPEN_CYCLES(5)) u5 (
    .clk(clk), .rst(rst), .req(req5), .wdata(wdata_b), .waddr(waddr_b),
    .gnt(gnt5), .done(done5), .lat_d(d5), .lat_en(en5), .lat_q(32'h0),
    .busy(busy5), .err(err5));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // issue one write on the main DUT, hold req until done, then return one cycle into IDLE
  task automatic do_write(input int r, input logic [7:0] data, input logic [1:0] addr);
    bit seen = 0;
    req = 4'(1) << r;
    wdata[r*8 +: 8] = data;
    waddr[r*2 +: 2] = addr;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (done[r]) seen = 1;
    end
    chk($sformatf("write_done_r%0d", r), 32'(seen), 32'd1);
    req = '0;
    tick();
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt, done, en;
    logic [7:0] d;
    logic       busy;
  } vec_t;
  vec_t tv [6];

  int   order [5] = '{0, 1, 2, 3, 0};
  int   n, last, cnt1, cnt5;
  logic [3:0] prev;

  initial begin
    // inputs for one cycle -> registered outputs seen in the following cycle
    tv[0] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 8'hA5, 1'b1};
    tv[1] = '{4'b0001, 4'b0001, 4'b0000, 4'b0100, 8'hA5, 1'b1};
    tv[2] = '{4'b0001, 4'b0001, 4'b0000, 4'b0100, 8'hA5, 1'b1};
    tv[3] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 8'hA5, 1'b1};
    tv[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'hA5, 1'b0};
    tv[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'hA5, 1'b0};

    do_reset();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_en", 32'(lat_en), 0);
    chk("rst_d", 32'(lat_d), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);

    // basic single write
    wdata[7:0] = 8'hA5;
    waddr[1:0] = 2'd2;
    for (int i = 0; i < 6; i++) begin
      req = tv[i].req;
      tick();
      chk($sformatf("t1_gnt_c%0d", i+1), 32'(gnt), 32'(tv[i].gnt));
      chk($sformatf("t1_done_c%0d", i+1), 32'(done), 32'(tv[i].done));
      chk($sformatf("t1_en_c%0d", i+1), 32'(lat_en), 32'(tv[i].en));
      chk($sformatf("t1_d_c%0d", i+1), 32'(lat_d), 32'(tv[i].d));
      chk($sformatf("t1_busy_c%0d", i+1), 32'(busy), 32'(tv[i].busy));
    end
    chk("t1_bank2", 32'(bank[2]), 32'hA5);

    // all requesters pending: rotation and spacing
    do_reset();
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    waddr = {2'd3, 2'd2, 2'd1, 2'd0};
    req = 4'b1111;
    n = 0; last = 0; prev = '0;
    for (int c = 1; c <= 40 && n < 5; c++) begin
      tick();
      chk("t2_onehot", 32'($countones(gnt) <= 1), 1);
      if (gnt != 0 && prev == 0) begin
        chk($sformatf("t2_gnt_%0d", n), 32'(gnt), 32'(4'(1) << order[n]));
        chk($sformatf("t2_d_%0d", n), 32'(lat_d), 32'(8'h11 * (order[n] + 1)));
        if (n > 0) chk($sformatf("t2_gap_%0d", n), 32'(c - last), 5);
        last = c;
        n++;
      end
      prev = gnt;
    end
    chk("t2_count", 32'(n), 5);
    req = '0;

    // inputs change under an in-flight transaction
    do_reset();
    wdata = '0; waddr = '0;
    req = 4'b0010;
    wdata[15:8] = 8'h5A;
    waddr[3:2] = 2'd1;
    tick();
    tick();
    chk("t3_en_c2", 32'(lat_en), 32'b0010);
    req = '0;
    wdata = 32'hFFFF_FFFF;
    waddr = 8'hFF;
    tick();
    chk("t3_en_c3", 32'(lat_en), 32'b0010);
    chk("t3_d_c3", 32'(lat_d), 32'h5A);
    tick();
    chk("t3_done", 32'(done), 32'b0010);
    chk("t3_d_hold", 32'(lat_d), 32'h5A);
    chk("t3_en_hold", 32'(lat_en), 0);
    tick();
    chk("t3_gnt_idle", 32'(gnt), 0);
    chk("t3_bank1", 32'(bank[1]), 32'h5A);
    chk("t3_bank3", 32'(bank[3]), 32'h44);

    // reset during OPEN
    do_reset();
    wdata = '0; waddr = '0;
    wdata[7:0] = 8'hA0;
    req = 4'b0001;
    tick();
    tick();
    chk("t4_in_open", 32'(lat_en), 32'b0001);
    rst = 1'b1;
    tick();
    chk("t4_en", 32'(lat_en), 0);
    chk("t4_gnt", 32'(gnt), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_done", 32'(done), 0);
    rst = 1'b0;
    req = 4'b0011;
    wdata[15:8] = 8'hB1;
    tick();
    chk("t4_next_gnt", 32'(gnt), 32'b0001);
    req = '0;
    for (int c = 0; c < 5; c++) tick();
    chk("t4_idle", 32'(busy), 0);

    // readback corruption
    do_reset();
    corrupt = 1'b1;
    do_write(0, 8'h3C, 2'd2);
    chk("t5_err_set", 32'(err), 32'(EXP_ERR));
    corrupt = 1'b0;
    do_write(1, 8'h77, 2'd2);
    chk("t5_err_sticky", 32'(err), 32'(EXP_ERR));
    do_reset();
    chk("t5_err_rst", 32'(err), 0);

    // OPEN_CYCLES = 1 and 5 envelopes
    wdata_b = 32'h0000_00C3;
    waddr_b = 8'h03;
    req1 = 4'b0001;
    req5 = 4'b0001;
    cnt1 = 0; cnt5 = 0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      req1 = '0;
      req5 = '0;
      cnt1 += (en1 != 0) ? 1 : 0;
      cnt5 += (en5 != 0) ? 1 : 0;
      chk($sformatf("t6_en1_c%0d", c), 32'(en1), (c == 2) ? 32'b1000 : 0);
      chk($sformatf("t6_done1_c%0d", c), 32'(done1), (c == 3) ? 32'b0001 : 0);
      chk($sformatf("t6_gnt1_c%0d", c), 32'(gnt1), (c <= 3) ? 32'b0001 : 0);
      chk($sformatf("t6_en5_c%0d", c), 32'(en5), (c >= 2 && c <= 6) ? 32'b1000 : 0);
      chk($sformatf("t6_done5_c%0d", c), 32'(done5), (c == 7) ? 32'b0001 : 0);
      chk($sformatf("t6_gnt5_c%0d", c), 32'(gnt5), (c <= 7) ? 32'b0001 : 0);
    end
    chk("t6_width1", 32'(cnt1), 1);
    chk("t6_width5", 32'(cnt5), 5);
    chk("t6_d5", 32'(d5), 32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/latch_bank_arbiter.md
Name: latch_bank_arbiter

Overview:
Round-robin controller that shares one bank of 2^AW level-sensitive D-latch words (DW bits each) among NREQ write requesters. It arbitrates requests and presents the granted data on the shared latch D bus. It sequences each write as SETUP → OPEN → HOLD so that data is stable before the addressed word's enable rises and after it falls. It sits between synchronous requester logic and the latch-based register bank, and is the only driver of the bank's D and enable lines.

Parameters:
NREQ, 4, number of requesters (≥2)
DW, 8, latch word width in bits
AW, 2, word address width; the bank holds 2^AW words
OPEN_CYCLES, 2, clock cycles that the selected enable is held high (≥1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
req  input  NREQ  per-requester write request, level; held until the matching done
wdata  input  NREQ*DW  write data; requester i uses bits [i*DW +: DW]
waddr  input  NREQ*AW  target word; requester i uses bits [i*AW +: AW]
gnt  output  NREQ  one-hot grant; high for the whole transaction
done  output  NREQ  one-hot, one-cycle completion pulse
lat_d  output  DW  shared D bus to all latch words
lat_en  output  2^AW  per-word latch enable; at most one bit high
lat_q  input  (2^AW)*DW  latch bank Q outputs; used only by the optional feature
busy  output  1  high in every state except IDLE
err  output  1  sticky readback-mismatch flag; only driven by the optional feature

Behaviour:
- All outputs are registered. Clock is clk; reset is rst, synchronous and active-high.
- Reset values: state=IDLE, gnt=0, done=0, lat_en=0, lat_d=0, busy=0, err=0, rr pointer=NREQ-1 (so requester 0 wins first).
- Reset asserted mid-transaction: on that edge lat_en goes to 0 and the FSM enters IDLE. No done pulse is issued and the interrupted word is undefined.
- IDLE:
  - If req is nonzero, pick the first asserted requester scanning upward from rr+1 (mod NREQ).
  - Capture its wdata/waddr into internal registers, set gnt[sel]=1 and rr=sel, go to SETUP.
  - If req is zero, stay in IDLE. lat_d keeps its last value; it is never zeroed outside reset.
- SETUP (1 cycle): lat_d=captured data, lat_en all zero.
- OPEN (OPEN_CYCLES cycles): lat_en[addr]=1 and lat_d held stable. A down-counter sets the duration.
- HOLD (1 cycle): lat_en=0, lat_d still held, done[sel]=1. The next state is IDLE, where gnt clears.
- Timing: req sampled in IDLE at cycle 0 gives gnt high in cycles 1..OPEN_CYCLES+2. lat_en is high in cycles 2..OPEN_CYCLES+1, and done pulses in cycle OPEN_CYCLES+2.
- Throughput: at least one IDLE cycle between transactions, so one write per OPEN_CYCLES+3 cycles.
- Captured wdata/waddr are frozen at grant. Later changes on the inputs, or req dropping early, do not affect the transaction in flight; it always completes.
- A requester that keeps req high after its done is re-arbitrated normally. Round-robin ordering puts every other pending requester ahead of it.
- Two requesters targeting the same address are serialized; the last granted write wins.
- lat_en is never high in SETUP, HOLD or IDLE, and never has two bits set.

Optional Feature:
LATCH_VERIFY_EN
- Defined: in HOLD, compare lat_q word [addr] against the captured data. On mismatch, err is set on the next edge and stays 1 until rst. done still pulses normally.
- Undefined: lat_q is ignored, err is tied to 0, and no compare logic is built. The port list is identical in both builds.

Test Plan:
1. Defaults, rst then req=4'b0001, wdata[7:0]=8'hA5, waddr[1:0]=2'd2 → gnt=0001 in cycles 1–4; lat_d=A5 from cycle 1; lat_en=4'b0100 in cycles 2–3 only; done=0001 in cycle 4; busy low again in cycle 5.
2. req=4'b1111 held continuously → grant order 0,1,2,3,0, one transaction per 5 cycles, never more than one gnt bit high.
3. req[1] dropped and wdata changed during OPEN → transaction completes with the originally captured data; done[1] still pulses.
4. rst asserted while in OPEN → lat_en=0, gnt=0, busy=0 on that edge; no done pulse; next grant goes to requester 0.
5. LATCH_VERIFY_EN defined, bench model forces lat_q word 2 to 8'h00 for a write of 8'h3C → err=1 the cycle after HOLD and stays 1 through later correct writes until rst. Macro undefined, same stimulus → err stays 0.
6. OPEN_CYCLES=1 and OPEN_CYCLES=5 → lat_en pulse is exactly 1 and 5 cycles wide, with one SETUP and one HOLD cycle around it.
